// File: rtl/multiplexor_display_7seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
//   - estado_t    : state encoding of the binary-to-BCD converter FSM
//   - SEG_APAGADO : all segments and dp off (active-low)
//   - SEG_GUION   : only segment g lit, dp off (overflow dash)
//   - seg_de_bcd  : BCD digit -> segments a..g, active-low; codes 10-15 blank
package pkg_display7seg;

  typedef enum logic {
    REPOSO    = 1'b0,
    CONVIERTE = 1'b1
  } estado_t;

  localparam logic [7:0] SEG_APAGADO = 8'hFF;
  localparam logic [7:0] SEG_GUION   = 8'hFD;

  // Result bit 6 = a ... bit 0 = g, 0 lights the segment.
  function automatic logic [6:0] seg_de_bcd(input logic [3:0] d);
    case (d)
      4'd0:    seg_de_bcd = 7'b0000001;
      4'd1:    seg_de_bcd = 7'b1001111;
      4'd2:    seg_de_bcd = 7'b0010010;
      4'd3:    seg_de_bcd = 7'b0000110;
      4'd4:    seg_de_bcd = 7'b1001100;
      4'd5:    seg_de_bcd = 7'b0100100;
      4'd6:    seg_de_bcd = 7'b0100000;
      4'd7:    seg_de_bcd = 7'b0001111;
      4'd8:    seg_de_bcd = 7'b0000000;
      4'd9:    seg_de_bcd = 7'b0000100;
      default: seg_de_bcd = 7'b1111111;
    endcase
  endfunction

endpackage

// File: rtl/multiplexor_display_7seg_conversor.sv
// Sequential binary-to-BCD converter (double-dabble, one iteration per clock).
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high
//   inicio   : start strobe, honoured only while idle
//   bin      : binary value, captured on an accepted inicio
//   bcd      : DIGITS BCD nibbles; valid in the cycle fin is high
//   desborde : captured value does not fit in DIGITS decimal digits
//   fin      : high during the cycle whose closing edge completes the last iteration
//   ocupado  : conversion in progress
module conversor_bin_bcd
  import pkg_display7seg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inicio,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  desborde,
  output logic                  fin,
  output logic                  ocupado
);

  localparam int         SR_W   = WIDTH + 4 * DIGITS;
  localparam int         CNT_W  = $clog2(WIDTH + 1);
  localparam logic [63:0] LIMITE = 64'(10 ** DIGITS);

  estado_t              estado_q;
  logic [SR_W-1:0]      sr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 desb_q;
  logic [SR_W-1:0]      sr_aj;
  logic [SR_W-1:0]      sr_d;

  // Add-3 correction on every BCD nibble, then shift the whole register.
  always_comb begin
    // NOTE: assigning a default before any conditional keeps always_comb free of latches.
    sr_aj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[WIDTH + 4*i +: 4] >= 4'd5)
        sr_aj[WIDTH + 4*i +: 4] = sr_q[WIDTH + 4*i +: 4] + 4'd3;
    end
    sr_d = {sr_aj[SR_W-2:0], 1'b0};
  end

  // The final shifted value is exposed combinationally so the display
  // register can load it on the same edge that ends the conversion.
  assign fin      = (estado_q == CONVIERTE) && (cnt_q == CNT_W'(WIDTH - 1));
  assign bcd      = sr_d[SR_W-1 -: 4*DIGITS];
  assign desborde = desb_q;
  assign ocupado  = (estado_q == CONVIERTE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      estado_q <= REPOSO;
      sr_q     <= '0;
      cnt_q    <= '0;
      desb_q   <= 1'b0;
    end else begin
      case (estado_q)
        REPOSO: begin
          if (inicio) begin
            sr_q     <= {{(4*DIGITS){1'b0}}, bin};
            cnt_q    <= '0;
            desb_q   <= (64'(bin) >= LIMITE);
            estado_q <= CONVIERTE;
          end
        end
        CONVIERTE: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (fin) estado_q <= REPOSO;
        end
        default: estado_q <= REPOSO;
      endcase
    end
  end

endmodule

// File: rtl/multiplexor_display_7seg.sv
// Multiplexed common-anode 7-segment display driver.
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high
//   valor   : unsigned value to display, sampled on an accepted cargar
//   cargar  : load strobe, accepted only while ocupado=0
//   punto   : per-digit decimal-point mask, sampled live
//   ocupado : conversion in progress
//   listo   : one-cycle pulse when the displayed value updates
//   catodos : segments active-low, bit7=a .. bit1=g, bit0=dp
//   anodos  : digit enables active-low, bit DIGITS-1 = leftmost digit
module multiplexor_display_7seg
  import pkg_display7seg::*;
#(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 14,
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  valor,
  input  logic              cargar,
  input  logic [DIGITS-1:0] punto,
  output logic              ocupado,
  output logic              listo,
  output logic [7:0]        catodos,
  output logic [DIGITS-1:0] anodos
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] bcd;
  logic                desborde;
  logic                fin;

  logic [PRE_W-1:0]    pre_q;
  logic [IDX_W-1:0]    idx_q;
  logic                activo_q;
  logic [4*DIGITS-1:0] disp_q;
  logic                ovf_q;
  logic                listo_q;
  logic [7:0]          catodos_q;
  logic [DIGITS-1:0]   anodos_q;

  logic                wrap;
  logic [3:0]          digito;
  logic                todo_cero;
  logic                blanco;
  logic [6:0]          seg;
  logic [7:0]          catodos_d;
  logic [DIGITS-1:0]   anodos_d;

  conversor_bin_bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conversor (
    .clk      (clk),
    .reset    (reset),
    .inicio   (cargar),
    .bin      (valor),
    .bcd      (bcd),
    .desborde (desborde),
    .fin      (fin),
    .ocupado  (ocupado)
  );

  assign wrap = (pre_q == PRE_W'(SCAN_DIV - 1));

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    digito    = disp_q[4*idx_q +: 4];
    todo_cero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((IDX_W'(j) >= idx_q) && (disp_q[4*j +: 4] != 4'd0)) todo_cero = 1'b0;
    end
    blanco = BLANK_LZ && (idx_q != '0) && todo_cero;
    if (ovf_q)       seg = SEG_GUION[7:1];
    else if (blanco) seg = SEG_APAGADO[7:1];
    else             seg = seg_de_bcd(digito);
    catodos_d = {seg, ~punto[idx_q]};
    anodos_d  = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q     <= '0;
      idx_q     <= IDX_W'(DIGITS - 1);
      activo_q  <= 1'b0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      listo_q   <= 1'b0;
      catodos_q <= SEG_APAGADO;
      anodos_q  <= '1;
    end else begin
      pre_q <= wrap ? '0 : pre_q + 1'b1;

      // The first wrap only enables scanning so the leftmost digit lights first.
      if (wrap) begin
        activo_q <= 1'b1;
        if (activo_q)
          idx_q <= (idx_q == '0) ? IDX_W'(DIGITS - 1) : idx_q - 1'b1;
      end

      listo_q <= fin;
      if (fin) begin
        disp_q <= bcd;
        ovf_q  <= desborde;
      end

      if (activo_q) begin
        catodos_q <= catodos_d;
        anodos_q  <= anodos_d;
      end
    end
  end

  assign listo   = listo_q;
  assign catodos = catodos_q;
  assign anodos  = anodos_q;

endmodule

// File: doc/multiplexor_display_7seg.md
# multiplexor_display_7seg

Parametrised driver for a multiplexed common-anode 7-segment display. It converts an unsigned binary value to BCD over several cycles and scans `DIGITS` digits with a programmable refresh period. It blanks leading zeros, shows an overflow indication, and applies a per-digit decimal-point mask. It sits between the measurement/control logic (current, frequency) and the board display pins, and replaces fixed-value segment lookup.

## Interface
- `DIGITS`, 4, number of display digits; must be 1..8.
- `WIDTH`, 14, width of the binary input value; must be 1..32.
- `SCAN_DIV`, 50000, clock cycles each digit stays enabled; must be ≥2.
- `BLANK_LZ`, 1, 1 = blank leading zeros, 0 = show all zeros.

- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `valor` in WIDTH: unsigned value to display; sampled only on an accepted `cargar`.
- `cargar` in 1: load strobe; accepted only when `ocupado`=0.
- `punto` in DIGITS: decimal-point mask; bit i lights the dp of digit i; sampled live.
- `ocupado` out 1: conversion in progress.
- `listo` out 1: one-cycle pulse when the displayed value updates.
- `catodos` out 8: segments, active-low; bit7=a … bit1=g, bit0=dp.
- `anodos` out DIGITS: digit enables, active-low; bit DIGITS-1 = leftmost (most significant) digit.

## Operation
- **FSM states:** REPOSO, CONVIERTE.
- **REPOSO:**
  - `cargar`=1 captures `valor` into the shift register, clears the BCD field and the iteration counter, and moves to CONVIERTE.
- **CONVIERTE:**
  - Runs double-dabble, one iteration per clock: each BCD nibble ≥5 gets +3, then the combined register shifts left by 1.
  - After WIDTH iterations, the BCD result and the overflow flag load into the display register and the FSM returns to REPOSO.
  - `cargar` is ignored in this state; there is no queueing.
- **Overflow:** set when the captured `valor` ≥ 10^DIGITS (compare against a localparam). The display register then shows a dash (`8'b11111101`) on every digit.
- **Width rules:**
  - Shift register is WIDTH + 4·DIGITS bits.
  - BCD nibbles beyond DIGITS are dropped; overflow covers that case.
- **Scanning:**
  - The prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances from DIGITS-1 down to 0, then wraps back to DIGITS-1.
  - Exactly one `anodos` bit is low at any time after the first tick.
- **Blanking:** when BLANK_LZ=1, a zero digit outputs `8'hFF` (dp mask still applied) if every more-significant digit is also zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
- **Decimal point:** `catodos[0]` = ~`punto`[index], overridden by nothing; it applies on blank digits and on overflow dashes too.
- **Display register:** changes only on the conversion-done edge; the old value stays shown throughout a conversion.

## Timing
- **Reset values:**
  - `catodos`=`8'hFF`, `anodos`=all ones, `ocupado`=0, `listo`=0.
  - Display register = 0, overflow = 0, digit index = DIGITS-1, prescaler = 0.
- **Conversion latency:**
  - Edge N samples `cargar`=1.
  - `ocupado`=1 from edge N through the edge completing iteration WIDTH.
  - At edge N+WIDTH, `listo`=1 for one cycle, the display register updates, and `ocupado`=0.
  - A new `cargar` is accepted at edge N+WIDTH+1 at the earliest. A `cargar` sampled at the completion edge N+WIDTH is ignored.
- **Outputs:** `catodos`/`anodos` are registered and update one cycle after the prescaler wrap or the display-register change.
- **Display after reset:** the first digit enables SCAN_DIV+1 cycles after reset release.
- **Reset mid-conversion:** abort immediately, force reset values, discard the partial result.
- **Simultaneous events:** a prescaler wrap coinciding with the display-register update shows the new value on the new digit.

## Structure
- **Shared package `pkg_display7seg`:**
  - function `seg_de_bcd` (4-bit → 7 segment bits, active-low; codes 10–15 → blank);
  - constants `SEG_APAGADO`=`8'hFF`, `SEG_GUION`=`8'hFD`;
  - the FSM state encoding.
- **Sub-module `conversor_bin_bcd`** (parameters WIDTH, DIGITS):
  - ports `clk`, `reset`, `inicio`, `bin`, `bcd`, `desborde`, `fin`, `ocupado`;
  - it contains the FSM and the shift register.
- **Top level:** prescaler, digit index, display register, blanking and dp logic.

## Test plan
DIGITS=4, WIDTH=14, SCAN_DIV=4 in all scenarios.
- **Load 1000:** `listo` pulses 14 cycles after `cargar`. Digits 3..0 show `10011111`, `00000011`, `00000011`, `00000011`; scanning enables `anodos` `0111`, `1011`, `1101`, `1110`, then wraps.
- **Load 30:** digits 3 and 2 = `8'hFF`, digit 1 = `00001101`, digit 0 = `00000011`. With BLANK_LZ=0, digits 3 and 2 = `00000011`.
- **Load 0, `punto`=`4'b0100`:** digit 0 = `00000011`; digit 2 = `11111110`; digits 3 and 1 = `8'hFF`.
- **Load 12000:** overflow; all four digits show `11111101`.
- **`cargar`=1 held for 20 cycles with `valor` changing:** only the first value is converted; the second acceptance happens at edge N+15 with the `valor` present then.
- **Reset asserted at iteration 7 of loading 250:** all outputs return to reset values at once. After release, the display shows "0" (digit 0 only) and `listo` never pulses.
